// File: rtl/jtpang_objdma.sv
// Object DMA for the Pang board: on a dma_go edge it takes the Z80 bus and copies the object
// table from video RAM into the object line buffer. Optional macro: JTPANG_OBJDMA_VB_EN.
module jtpang_objdma #(
  parameter int unsigned       SRC_AW   = 12,
  parameter int unsigned       DST_AW   = 9,
  parameter int unsigned       LEN      = 512,
  parameter logic [SRC_AW-1:0] SRC_BASE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dma_go,
  input  logic              LVBL,
  output logic              busrq_n,
  input  logic              busak_n,
  output logic              src_cs,
  output logic [SRC_AW-1:0] src_addr,
  input  logic [7:0]        src_dout,
  output logic [DST_AW-1:0] buf_addr,
  output logic [7:0]        buf_din,
  output logic              buf_we,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {StIdle, StReq, StXfer, StDrain, StRel} state_e;

  state_e            state_q, state_d;
  logic              go_l_q;
  logic              pend_q, pend_d;
  logic [DST_AW:0]   cnt_q, cnt_d;
  logic              rd_v_q;
  logic [DST_AW-1:0] rd_a_q;
  logic              go_event;
  logic              last_rd;
  logic              vb_ok;

  assign go_event = dma_go & ~go_l_q;
  assign last_rd  = (32'(cnt_q) == LEN - 1);

`ifdef JTPANG_OBJDMA_VB_EN
  assign vb_ok = ~LVBL;
`else
  // LVBL is kept referenced in this build, but the start condition ignores it.
  assign vb_ok = LVBL | 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q | go_event;
    cnt_d   = cnt_q;
    busrq_n = 1'b1;
    busy    = 1'b0;
    done    = 1'b0;
    src_cs  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pend_q && vb_ok) begin
          state_d = StReq;
          pend_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      StReq: begin
        busrq_n = 1'b0;
        busy    = 1'b1;
        if (!busak_n) state_d = StXfer;
      end
      StXfer: begin
        busrq_n = 1'b0;
        busy    = 1'b1;
        // Losing the grant simply stalls the copy at the current count.
        if (!busak_n && (32'(cnt_q) < LEN)) begin
          src_cs = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (last_rd) state_d = StDrain;
        end
      end
      StDrain: begin
        busrq_n = 1'b0;
        busy    = 1'b1;
        state_d = StRel;
      end
      StRel: begin
        done  = 1'b1;
        cnt_d = '0;
        // An edge arriving together with done still chains straight into a new request.
        if ((pend_q || go_event) && vb_ok) begin
          state_d = StReq;
          pend_d  = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      go_l_q  <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      rd_v_q  <= 1'b0;
      rd_a_q  <= '0;
    end else begin
      state_q <= state_d;
      go_l_q  <= dma_go;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      rd_v_q  <= src_cs;
      if (src_cs) rd_a_q <= cnt_q[DST_AW-1:0];
    end
  end

  assign src_addr = SRC_BASE + SRC_AW'(cnt_q);
  assign buf_we   = rd_v_q;
  assign buf_addr = rd_a_q;
  assign buf_din  = rd_v_q ? src_dout : 8'h00;

endmodule
